// File: rtl/msk_tx_timing.sv
// MSK transmit bit timing: paces a serial stream into offset I/Q
// branch bits with sync strobes and a bit-timing square wave.
module msk_tx_timing #(
   parameter int P       = 16,
   parameter int CNT_W   = 6,
   parameter bit DIFF_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   input  logic din_valid,
   output logic din_ready,
   output logic i_bit,
   output logic q_bit,
   output logic i_sync,
   output logic q_sync,
   output logic sym_clk,
   output logic underrun
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(2*P-1);
   localparam logic [CNT_W-1:0] MID  = CNT_W'(P-1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(P);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             prev;
   logic             i_sync_q;
   logic             q_sync_q;
   logic             slot_i;
   logic             slot_q;
   logic             bit_in;
   logic             enc;

   always_comb begin
      cnt_nxt = cnt;
      if (en) begin
         cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign slot_i    = en && (cnt == LAST);
   assign slot_q    = en && (cnt == MID);
   assign din_ready = slot_i || slot_q;

   // a missing bit is sent as 0 so the branch timing never slips
   assign bit_in = din_valid & din;
   assign enc    = DIFF_EN ? (bit_in ^ prev) : bit_in;

   // strobes survive an en=0 stall and fire on the first enabled cycle
   assign i_sync = i_sync_q & en;
   assign q_sync = q_sync_q & en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= HALF;
         prev     <= 1'b0;
         i_bit    <= 1'b0;
         q_bit    <= 1'b0;
         i_sync_q <= 1'b0;
         q_sync_q <= 1'b0;
         sym_clk  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (en) begin
            sym_clk  <= (cnt_nxt < HALF);
            i_sync_q <= slot_i;
            q_sync_q <= slot_q;
         end
         if (slot_i) begin
            i_bit <= enc;
         end
         if (slot_q) begin
            q_bit <= enc;
         end
         if (din_ready) begin
            prev <= enc;
            if (!din_valid) begin
               underrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_msk_tx_timing.sv
// Bench for msk_tx_timing: directed test-plan runs plus random traffic
// against a behavioural model, on plain and differential instances.
module tb_msk_tx_timing;

   localparam int P = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic din = 1'b0;
   logic din_valid = 1'b0;

   logic rdy0, ib0, qb0, is0, qs0, sym0, und0;
   logic rdy1, ib1, qb1, is1, qs1, sym1, und1;

   int checks = 0;
   int errors = 0;

   // behavioural model
   int m_cnt;
   bit m_started;
   bit m_par;
   bit m_ib0, m_qb0, m_ib1, m_qb1, m_und;

   logic l_rdy0 [0:255];
   logic l_ib0  [0:255];
   logic l_qb0  [0:255];
   logic l_ib1  [0:255];
   logic l_qb1  [0:255];
   logic l_is0  [0:255];
   logic l_qs0  [0:255];
   logic l_sym0 [0:255];
   logic l_und0 [0:255];

   always #5 clk = ~clk;

   msk_tx_timing #(.P(P), .CNT_W(6), .DIFF_EN(1'b0)) d0 (
      .clk(clk), .rst(rst), .en(en), .din(din),
      .din_valid(din_valid), .din_ready(rdy0),
      .i_bit(ib0), .q_bit(qb0), .i_sync(is0), .q_sync(qs0),
      .sym_clk(sym0), .underrun(und0)
   );

   msk_tx_timing #(.P(P), .CNT_W(6), .DIFF_EN(1'b1)) d1 (
      .clk(clk), .rst(rst), .en(en), .din(din),
      .din_valid(din_valid), .din_ready(rdy1),
      .i_bit(ib1), .q_bit(qb1), .i_sync(is1), .q_sync(qs1),
      .sym_clk(sym1), .underrun(und1)
   );

   task automatic chk(input string n, input logic a, input logic x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", n, a, x);
      end
   endtask

   task automatic chk_i(input string n, input int a, input int x);
      checks++;
      if (a != x) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", n, a, x);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_rdy0", rdy0, 1'b0);
      chk("rst_rdy1", rdy1, 1'b0);
      chk("rst_ib0", ib0, 1'b0);
      chk("rst_qb0", qb0, 1'b0);
      chk("rst_ib1", ib1, 1'b0);
      chk("rst_qb1", qb1, 1'b0);
      chk("rst_is", is0 | is1, 1'b0);
      chk("rst_qs", qs0 | qs1, 1'b0);
      chk("rst_sym", sym0 | sym1, 1'b0);
      chk("rst_und", und0 | und1, 1'b0);
      m_cnt = P;
      m_started = 0;
      m_par = 0;
      m_ib0 = 0; m_qb0 = 0; m_ib1 = 0; m_qb1 = 0;
      m_und = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // one clock cycle: drive, compare everything, advance the model
   task automatic cyc(input bit e, input bit v, input bit d, input int c);
      bit slot, b, e1;
      en = e; din_valid = v; din = d;
      #1;
      slot = e && (m_cnt == 2*P-1 || m_cnt == P-1);
      chk("din_ready0", rdy0, slot);
      chk("din_ready1", rdy1, slot);
      chk("i_bit0", ib0, m_ib0);
      chk("q_bit0", qb0, m_qb0);
      chk("i_bit1", ib1, m_ib1);
      chk("q_bit1", qb1, m_qb1);
      chk("i_sync0", is0, e && m_cnt == 0 && m_started);
      chk("i_sync1", is1, e && m_cnt == 0 && m_started);
      chk("q_sync0", qs0, e && m_cnt == P && m_started);
      chk("q_sync1", qs1, e && m_cnt == P && m_started);
      chk("sym_clk0", sym0, m_cnt < P);
      chk("sym_clk1", sym1, m_cnt < P);
      chk("underrun0", und0, m_und);
      chk("underrun1", und1, m_und);
      if (c >= 0 && c < 256) begin
         l_rdy0[c] = rdy0; l_ib0[c] = ib0; l_qb0[c] = qb0;
         l_ib1[c] = ib1; l_qb1[c] = qb1; l_is0[c] = is0;
         l_qs0[c] = qs0; l_sym0[c] = sym0; l_und0[c] = und0;
      end
      if (slot) begin
         b = v & d;
         if (!v) m_und = 1;
         // differential bit is the running parity of all inputs
         e1 = m_par ^ b;
         m_par = e1;
         if (m_cnt == 2*P-1) begin
            m_ib0 = b; m_ib1 = e1; m_started = 1;
         end else begin
            m_qb0 = b; m_qb1 = e1;
         end
      end
      if (e) m_cnt = (m_cnt + 1) % (2*P);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input logic [3:0] s, input int n, input int bad,
                      input int off_s, input int off_n);
      int idx = 0;
      for (int c = 0; c < n; c++) begin
         bit e, v, d;
         e = !(c >= off_s && c < off_s + off_n);
         v = (c != bad);
         d = (idx < 4) ? s[3-idx] : 1'b1;
         cyc(e, v, d, c);
         if (l_rdy0[c] && v) idx++;
      end
   endtask

   function automatic int first_rdy(input int from, input int n);
      for (int c = from; c < n; c++) begin
         if (l_rdy0[c]) return c;
      end
      return -1;
   endfunction

   initial begin
      int cnt_hi, cnt_st;
      #2;
      do_reset();

      run(4'b1011, 66, -1, -1, 0);
      chk("t1_rdy15", l_rdy0[15], 1'b1);
      chk("t1_rdy31", l_rdy0[31], 1'b1);
      chk("t1_rdy47", l_rdy0[47], 1'b1);
      chk("t1_rdy63", l_rdy0[63], 1'b1);
      chk_i("t1_first_rdy", first_rdy(0, 66), 15);
      chk_i("t1_next_rdy", first_rdy(16, 66), 31);
      chk("t1_i16", l_ib0[16], 1'b1);
      chk("t1_is16", l_is0[16], 1'b1);
      chk("t1_q32", l_qb0[32], 1'b0);
      chk("t1_qs32", l_qs0[32], 1'b1);
      chk("t1_i48", l_ib0[48], 1'b1);
      chk("t1_q64", l_qb0[64], 1'b1);
      chk("t1_d_i16", l_ib1[16], 1'b1);
      chk("t1_d_q32", l_qb1[32], 1'b1);
      chk("t1_d_i48", l_ib1[48], 1'b0);
      chk("t1_d_q64", l_qb1[64], 1'b1);

      do_reset();
      run(4'b1101, 66, -1, -1, 0);
      chk("t2_d_i16", l_ib1[16], 1'b1);
      chk("t2_d_q32", l_qb1[32], 1'b0);
      chk("t2_d_i48", l_ib1[48], 1'b0);
      chk("t2_d_q64", l_qb1[64], 1'b1);

      do_reset();
      run(4'b1111, 128, 31, -1, 0);
      chk("t3_q32", l_qb0[32], 1'b0);
      chk("t3_qs32", l_qs0[32], 1'b1);
      chk("t3_und31", l_und0[31], 1'b0);
      chk("t3_und32", l_und0[32], 1'b1);
      chk("t3_und127", l_und0[127], 1'b1);
      cnt_hi = 0;
      for (int c = 0; c < 128; c++) cnt_hi += int'(l_sym0[c]);
      chk_i("t3_sym_high", cnt_hi, 64);
      chk("t3_sym_rise16", l_sym0[16] & ~l_sym0[15], 1'b1);
      chk("t3_sym_fall32", l_sym0[31] & ~l_sym0[32], 1'b1);

      do_reset();
      run(4'b1111, 60, -1, 26, 10);
      cnt_st = 0;
      for (int c = 26; c < 36; c++) begin
         cnt_st += int'(l_is0[c]) + int'(l_qs0[c]) + int'(l_rdy0[c]);
         if (l_ib0[c] !== l_ib0[25] || l_sym0[c] !== l_sym0[25])
            cnt_st++;
      end
      chk_i("t4_frozen", cnt_st, 0);
      chk_i("t4_resume_rdy", first_rdy(26, 60), 41);

      do_reset();
      run(4'b1111, 52, 31, -1, 0);
      chk("t5_i_pre", l_ib0[51], 1'b1);
      chk("t5_und_pre", l_und0[51], 1'b1);
      do_reset();
      run(4'b1111, 20, -1, -1, 0);
      chk_i("t5_first_rdy", first_rdy(0, 20), 15);
      chk("t5_i16", l_ib0[16], 1'b1);
      chk("t5_is16", l_is0[16], 1'b1);

      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(299) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(9) != 0, $urandom_range(6) != 0,
                1'($urandom), -1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
